// File: rtl/bm_dag_log_param.sv
//------------------------------------------------------------------------------
// Module   : bm_dag_log_param
// Purpose  : Valid-qualified capture, runtime-selected logic combine, DEPTH-stage
//            valid-tagged result pipeline with global stall and saturating match count.
// Revision : 1.0 - initial parametrised release
//------------------------------------------------------------------------------
`default_nettype none

module bm_dag_log_param #(
  parameter int BITS  = 2,
  parameter int DEPTH = 2,
  parameter int CNT_W = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ce,
  input  logic             in_valid,
  input  logic [1:0]       mode,
  input  logic [BITS-1:0]  a_in,
  input  logic [BITS-1:0]  b_in,
  input  logic             c_in,
  input  logic             d_in,
  output logic [BITS-1:0]  out0,
  output logic             out1,
  output logic             out_valid,
  output logic [CNT_W-1:0] match_count
);

  localparam logic [1:0]       c_OP_AND  = 2'b00;
  localparam logic [1:0]       c_OP_OR   = 2'b01;
  localparam logic [1:0]       c_OP_XOR  = 2'b10;
  localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

  function automatic logic [BITS-1:0] f_vec_op(input logic [1:0] m,
                                               input logic [BITS-1:0] x,
                                               input logic [BITS-1:0] y);
    case (m)
      c_OP_AND: f_vec_op = x & y;
      c_OP_OR:  f_vec_op = x | y;
      c_OP_XOR: f_vec_op = x ^ y;
      default:  f_vec_op = ~(x ^ y);
    endcase
  endfunction

  function automatic logic f_bit_op(input logic [1:0] m, input logic x, input logic y);
    case (m)
      c_OP_AND: f_bit_op = x & y;
      c_OP_OR:  f_bit_op = x | y;
      c_OP_XOR: f_bit_op = x ^ y;
      default:  f_bit_op = ~(x ^ y);
    endcase
  endfunction

  logic [BITS-1:0] r_a;
  logic [BITS-1:0] r_b;
  logic            r_c;
  logic            r_d;
  logic [1:0]      r_mode;
  logic            r_v0;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_c    <= 1'b0;
      r_d    <= 1'b0;
      r_mode <= 2'b00;
      r_v0   <= 1'b0;
    end else if (ce) begin
      r_v0 <= in_valid;
      if (in_valid) begin
        r_a    <= a_in;
        r_b    <= b_in;
        r_c    <= c_in;
        r_d    <= d_in;
        r_mode <= mode;
      end
    end
  end

  // Index 0 is the combined capture-stage result feeding stage 1; index k is stage k.
  logic            w_st_v  [0:DEPTH];
  logic [BITS-1:0] w_st_s0 [0:DEPTH];
  logic            w_st_s1 [0:DEPTH];

  assign w_st_v[0]  = r_v0;
  assign w_st_s0[0] = f_vec_op(r_mode, r_a, r_b);
  assign w_st_s1[0] = f_bit_op(r_mode, r_c, r_d);

  for (genvar k = 1; k <= DEPTH; k++) begin : g_stage
    logic [BITS-1:0] r_s0;
    logic            r_s1;
    logic            r_v;

    always_ff @(posedge clock) begin
      if (reset) begin
        r_s0 <= '0;
        r_s1 <= 1'b0;
        r_v  <= 1'b0;
      end else if (ce) begin
        r_v <= w_st_v[k-1];
        if (w_st_v[k-1]) begin
          r_s0 <= w_st_s0[k-1];
          r_s1 <= w_st_s1[k-1];
        end
      end
    end

    assign w_st_v[k]  = r_v;
    assign w_st_s0[k] = r_s0;
    assign w_st_s1[k] = r_s1;
  end

  // Counting on the edge that loads the last stage keeps the count coherent with out_valid.
  logic r_unused_guard;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_inc;

  assign w_cnt_inc = w_st_v[DEPTH-1] & w_st_s1[DEPTH-1] & (r_cnt != c_CNT_MAX);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt          <= '0;
      r_unused_guard <= 1'b0;
    end else if (ce) begin
      r_unused_guard <= 1'b0;
      if (w_cnt_inc) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign out0        = w_st_s0[DEPTH];
  assign out1        = w_st_s1[DEPTH];
  assign out_valid   = w_st_v[DEPTH];
  assign match_count = r_cnt | {CNT_W{r_unused_guard}};

endmodule

`default_nettype wire

// File: tb/tb_bm_dag_log_param.sv
//------------------------------------------------------------------------------
// Module   : tb_bm_dag_log_param
// Purpose  : Self-checking bench for bm_dag_log_param (CNT_W = 4 and CNT_W = 2 copies).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_bm_dag_log_param;

  localparam int BITS  = 2;
  localparam int DEPTH = 2;

  logic            clock = 1'b0;
  logic            reset;
  logic            ce;
  logic            in_valid;
  logic [1:0]      mode;
  logic [BITS-1:0] a_in;
  logic [BITS-1:0] b_in;
  logic            c_in;
  logic            d_in;

  logic [BITS-1:0] out0_4, out0_2;
  logic            out1_4, out1_2;
  logic            ov_4, ov_2;
  logic [3:0]      mc_4;
  logic [1:0]      mc_2;

  bm_dag_log_param #(.BITS(BITS), .DEPTH(DEPTH), .CNT_W(4)) u_dut4 (
    .clock(clock), .reset(reset), .ce(ce), .in_valid(in_valid), .mode(mode),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .out0(out0_4), .out1(out1_4), .out_valid(ov_4), .match_count(mc_4)
  );

  bm_dag_log_param #(.BITS(BITS), .DEPTH(DEPTH), .CNT_W(2)) u_dut2 (
    .clock(clock), .reset(reset), .ce(ce), .in_valid(in_valid), .mode(mode),
    .a_in(a_in), .b_in(b_in), .c_in(c_in), .d_in(d_in),
    .out0(out0_2), .out1(out1_2), .out_valid(ov_2), .match_count(mc_2)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: a sample captured on enabled edge n is delivered on enabled edge n+DEPTH.
  typedef struct {
    int              due;
    logic [1:0]      m;
    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic            c;
    logic            d;
  } samp_t;

  samp_t           q[$];
  samp_t           s;
  int              n_edge  = 0;
  bit              started = 0;
  bit              m_valid = 0;
  logic [BITS-1:0] m_out0  = '0;
  logic            m_out1  = 1'b0;
  int              m_cnt4  = 0;
  int              m_cnt2  = 0;

  function automatic int f_op(input logic [1:0] m, input int x, input int y, input int w);
    int mask;
    mask = (1 << w) - 1;
    case (m)
      2'b00:   f_op = x & y;
      2'b01:   f_op = x | y;
      2'b10:   f_op = x ^ y;
      default: f_op = (~(x ^ y)) & mask;
    endcase
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      q.delete();
      m_valid = 0;
      m_out0  = '0;
      m_out1  = 1'b0;
      m_cnt4  = 0;
      m_cnt2  = 0;
      n_edge  = 0;
      started = 1;
    end else if (ce) begin
      n_edge++;
      m_valid = 0;
      if (q.size() > 0 && q[0].due == n_edge) begin
        s       = q.pop_front();
        m_valid = 1;
        m_out0  = BITS'(f_op(s.m, int'(s.a), int'(s.b), BITS));
        m_out1  = 1'(f_op(s.m, int'(s.c), int'(s.d), 1));
        if (m_out1) begin
          if (m_cnt4 < 15) m_cnt4++;
          if (m_cnt2 < 3)  m_cnt2++;
        end
      end
      if (in_valid) q.push_back('{n_edge + DEPTH, mode, a_in, b_in, c_in, d_in});
    end
  end

  always @(negedge clock) begin
    if (started) begin
      check("out_valid_c4", int'(ov_4), int'(m_valid));
      check("out_valid_c2", int'(ov_2), int'(m_valid));
      check("out0_c4", int'(out0_4), int'(m_out0));
      check("out1_c4", int'(out1_4), int'(m_out1));
      check("out0_c2", int'(out0_2), int'(m_out0));
      check("match_count_c4", int'(mc_4), m_cnt4);
      check("match_count_c2", int'(mc_2), m_cnt2);
    end
  end

  task automatic step(input logic r, input logic e, input logic iv, input logic [1:0] m,
                      input logic [1:0] a, input logic [1:0] b, input logic c, input logic d);
    reset    = r;
    ce       = e;
    in_valid = iv;
    mode     = m;
    a_in     = a;
    b_in     = b;
    c_in     = c;
    d_in     = d;
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 1'b1, 1'b0, 2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
  endtask

  int exp_o0[4] = '{2, 3, 1, 2};
  int exp_o1[4] = '{0, 1, 1, 0};
  int exp_s2[5] = '{1, 2, 3, 3, 3};

  initial begin
    // Reset with a valid sample presented
    step(1'b1, 1'b1, 1'b1, 2'($urandom), 2'($urandom), 2'($urandom), 1'b1, 1'b1);
    check("rst_out0", int'(out0_4), 0);
    check("rst_out1", int'(out1_4), 0);
    check("rst_valid", int'(ov_4), 0);
    check("rst_count", int'(mc_4), 0);
    for (int i = 0; i < 3; i++) begin
      idle();
      check("rst_no_valid", int'(ov_4), 0);
    end

    // Single sample
    step(1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 2'b10, 1'b1, 1'b1);
    idle();
    check("single_early", int'(ov_4), 0);
    idle();
    check("single_valid", int'(ov_4), 1);
    check("single_out0", int'(out0_4), 2);
    check("single_out1", int'(out1_4), 1);
    check("single_count", int'(mc_4), 1);
    idle();
    check("single_drop", int'(ov_4), 0);
    check("single_hold0", int'(out0_4), 2);
    check("single_hold1", int'(out1_4), 1);

    // Mode sweep back-to-back
    step(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      step(1'b0, 1'b1, (k < 4), 2'(k), 2'b10, 2'b11, 1'b1, 1'b0);
      if (k >= 2) begin
        check("sweep_valid", int'(ov_4), 1);
        check("sweep_out0", int'(out0_4), exp_o0[k-2]);
        check("sweep_out1", int'(out1_4), exp_o1[k-2]);
      end
    end
    check("sweep_count", int'(mc_4), 2);

    // Stall on edges 1 and 2
    step(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'b00, 2'b11, 2'b10, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 1'b1, 2'b01, 2'b01, 2'b01, 1'b1, 1'b1);
      check("stall_valid", int'(ov_4), 0);
      check("stall_count", int'(mc_4), 0);
    end
    idle();
    check("stall_early", int'(ov_4), 0);
    idle();
    check("stall_valid_out", int'(ov_4), 1);
    check("stall_out0", int'(out0_4), 2);
    check("stall_out1", int'(out1_4), 1);
    check("stall_count_out", int'(mc_4), 1);

    // Saturation, observed on the CNT_W = 2 copy
    step(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) begin
      step(1'b0, 1'b1, (k < 5), 2'b01, 2'($urandom), 2'($urandom), 1'b1, 1'b0);
      if (k >= 2) begin
        check("sat_count2", int'(mc_2), exp_s2[k-2]);
        check("sat_count4", int'(mc_4), k - 1);
      end
    end

    // Reset mid-flight, with ce low to show reset priority
    step(1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 2'b01, 2'b11, 2'b11, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 2'b01, 2'b11, 2'b11, 1'b1, 1'b1);
    for (int i = 2; i <= 5; i++) begin
      idle();
      check("midrst_valid", int'(ov_4), 0);
      check("midrst_count", int'(mc_4), 0);
    end

    // Mixed traffic checked against the model
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 3) != 0), 1'($urandom),
           2'($urandom), 2'($urandom), 2'($urandom), 1'($urandom), 1'($urandom));
    end

    @(negedge clock);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
